kfps2kb_send_command: RTL and testbench
=======================================

# kfps2kb_send_command

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, such as set-LEDs (0xED) or reset (0xFF). It is the transmit counterpart of the KFPS2KB receiver and drives the same open-drain clock and data lines. It asserts a `receiver_inhibit` flag so the receiver ignores the bus while a command is in flight.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: system clocks for which `device_clock` is held low. At 50 MHz this is 100 µs.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum system clocks between consecutive device-clock falling edges, and while waiting for bus release, before the command is aborted.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `device_clock` in 1: PS/2 clock line as read back from the pad.
- `device_data` in 1: PS/2 data line as read back from the pad.
- `device_clock_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `device_data_oe` out 1: 1 pulls the data line low; 0 releases it.
- `send_request` in 1: 1-cycle pulse that starts a transfer. Accepted only when `busy` is 0.
- `send_data` in 8: command byte, captured in the cycle where `send_request` is 1.
- `busy` out 1: high from the cycle after acceptance until `done` or `error` pulses.
- `done` out 1: 1-cycle pulse when the device has acknowledged and the bus has been released.
- `error` out 1: 1-cycle pulse on timeout or missing ACK.
- `receiver_inhibit` out 1: equals `busy`.

## Operation
- `device_clock` and `device_data` each pass through a 2-flop synchronizer. Falling-edge detection uses the synchronized clock and a third, delayed flop.
- Frame format: start bit 0, data bits D0–D7 LSB first, odd parity (bit = ~^data), stop bit 1, then the device drives ACK = 0.
- FSM states and transitions:
  - IDLE: both `oe` outputs 0. On `send_request`, latch `send_data` into the shift register, compute parity, then go to INHIBIT.
  - INHIBIT: `device_clock_oe` = 1 for `INHIBIT_CYCLES` cycles. Then go to REQUEST.
  - REQUEST: `device_data_oe` = 1 (start bit) and `device_clock_oe` = 0. Clear the bit counter and go to SEND.
  - SEND: counter n counts device-clock falling edges.
    - Falling edges 1–8: `device_data_oe` = ~D[n−1].
    - Falling edge 9: `device_data_oe` = ~parity.
    - Falling edge 10: `device_data_oe` = 0 (stop bit, line released).
    - Falling edge 11: sample synchronized data. If it is 0, go to WAIT_IDLE; if it is 1, go to ERROR.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse `done` and go to IDLE.
  - ERROR: release both lines, pulse `error`, go to IDLE.
- Timeout: a counter reloads on every falling edge and on every state entry.
  - It runs in REQUEST, SEND and WAIT_IDLE.
  - It is not active in INHIBIT.
  - Reaching `TIMEOUT_CYCLES` goes to ERROR.
- A `send_request` arriving while `busy` = 1 is ignored. No queueing.
- Reset mid-frame: all outputs return to 0 asynchronously and both lines are released. The device times out on its own.

## Timing
- Reset values: `device_clock_oe` = 0, `device_data_oe` = 0, `busy` = 0, `done` = 0, `error` = 0, `receiver_inhibit` = 0. Shift register, counters and FSM state are all cleared.
- `send_request` in cycle t:
  - `busy` = 1 and `device_clock_oe` = 1 at cycle t+1.
  - `device_clock_oe` falls and `device_data_oe` rises at t+1+`INHIBIT_CYCLES`.
  - Both changes are registered in the same cycle, so the data line is driven low before the clock line is released.
- Synchronizer latency: a pad edge is seen 3 system clocks later. The `device_data_oe` update therefore occurs 3 clocks after the physical falling edge.
- `done`/`error` is 1 for exactly one cycle. `busy` = 0 in that same cycle, so a new `send_request` is accepted in the next cycle.

## Structure
- Shared package `kfps2kb_pkg`:
  - the FSM state enum type,
  - frame constant `PS2_FALL_ACK = 11`,
  - function `ps2_odd_parity(byte)`.
- One sub-module, `kfps2kb_sync_edge`: a 2-flop synchronizer plus falling-edge detector. Also reusable by the receiver.
- Top-level tri-state pad: line = oe ? 0 : z, with a pull-up. This lives outside the block.

## Test plan
- Send 0xED with an emulated device that clocks at 30-cycle half-period and ACKs:
  - the emulator samples bits on rising edges and collects 0, 1,0,1,1,0,1,1,1, parity 1, stop 1 (start, D0–D7, parity, stop in wire order);
  - `done` pulses once and `error` stays 0.
- Send 0x00: the parity bit on the wire is 1 and `done` pulses.
- Device never clocks after the request:
  - `error` pulses exactly `TIMEOUT_CYCLES` (+1) clocks after REQUEST entry;
  - both `oe` outputs are 0 afterwards.
- Device gives no ACK (data stays 1 at falling edge 11): `error` pulses and `done` stays 0.
- `send_request` with 0x55 while `busy`: ignored, and only the first byte appears on the wire.
- Assert `reset` after falling edge 5: both `oe` outputs drop to 0 in the same cycle. A subsequent send of 0xFF completes with `done`.

Source files
------------

// File: rtl/kfps2kb_pkg.sv
// Shared definitions for the KFPS2KB PS/2 keyboard blocks: transmit FSM states,
// frame positions counted in device-clock falling edges, and the parity helper.
package kfps2kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SEND,
    ST_WAIT_IDLE,
    ST_ERROR
  } send_state_t;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_FALL_PARITY = 9;
  localparam int PS2_FALL_STOP   = 10;
  localparam int PS2_FALL_ACK    = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/kfps2kb_send_command_if.sv
// Host-side command handshake of the PS/2 transmitter: request/byte in,
// busy/done/error status and the receiver inhibit flag out.
interface kfps2kb_send_command_if;
  import kfps2kb_pkg::*;

  logic       send_request;
  logic [7:0] send_data;
  logic       busy;
  logic       done;
  logic       error;
  logic       receiver_inhibit;

  modport master (
    output send_request, send_data,
    input  busy, done, error, receiver_inhibit
  );

  modport slave (
    input  send_request, send_data,
    output busy, done, error, receiver_inhibit
  );

endinterface

// File: rtl/kfps2kb_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge strobe
// taken from a third, delayed flop. Shared with the receiver.
module kfps2kb_sync_edge
  import kfps2kb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta;
  logic stage;
  logic delayed;

  // Flops come up high (idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta    <= 1'b1;
      stage   <= 1'b1;
      delayed <= 1'b1;
    end else begin
      meta    <= line;
      stage   <= meta;
      delayed <= stage;
    end
  end

  assign sync = stage;
  assign fall = delayed & ~stage;

endmodule

// File: rtl/kfps2kb_send_command.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device-clock falling edges and checks the ACK.
module kfps2kb_send_command
  import kfps2kb_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic device_clock,
  input  logic device_data,
  output logic device_clock_oe,
  output logic device_data_oe,
  kfps2kb_send_command_if.slave host
);

  localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  send_state_t        state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [3:0]         fall_count, fall_count_next, fall_number;
  logic [7:0]         shift_q, shift_next;
  logic               parity_q, parity_next;
  logic               clock_oe_q, clock_oe_next;
  logic               data_oe_q, data_oe_next;
  logic               done_q, done_next;

  logic clock_sync;
  logic clock_fall;
  logic data_meta;
  logic data_sync;

  kfps2kb_sync_edge u_clock_sync (
    .clock (clock),
    .reset (reset),
    .line  (device_clock),
    .sync  (clock_sync),
    .fall  (clock_fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= device_data;
      data_sync <= data_meta;
    end
  end

  assign fall_number = fall_count + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      fall_count <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      fall_count <= fall_count_next;
      shift_q    <= shift_next;
      parity_q   <= parity_next;
      clock_oe_q <= clock_oe_next;
      data_oe_q  <= data_oe_next;
      done_q     <= done_next;
    end
  end

  // The shared timer paces INHIBIT and acts as the watchdog elsewhere.
  always_comb begin
    state_next      = state;
    timer_next      = timer + 1'b1;
    fall_count_next = fall_count;
    shift_next      = shift_q;
    parity_next     = parity_q;
    clock_oe_next   = clock_oe_q;
    data_oe_next    = data_oe_q;
    done_next       = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_next    = '0;
        clock_oe_next = 1'b0;
        data_oe_next  = 1'b0;
        if (host.send_request) begin
          shift_next    = host.send_data;
          parity_next   = ps2_odd_parity(host.send_data);
          clock_oe_next = 1'b1;
          state_next    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer == INHIBIT_LAST) begin
          clock_oe_next = 1'b0;
          data_oe_next  = 1'b1;
          state_next    = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        fall_count_next = '0;
        state_next      = ST_SEND;
      end
      ST_SEND: begin
        if (clock_fall) begin
          timer_next      = '0;
          fall_count_next = fall_number;
          if (fall_number <= 4'(PS2_DATA_BITS)) begin
            data_oe_next = ~shift_q[0];
            shift_next   = {1'b0, shift_q[7:1]};
          end else if (fall_number == 4'(PS2_FALL_PARITY)) begin
            data_oe_next = ~parity_q;
          end else if (fall_number == 4'(PS2_FALL_STOP)) begin
            data_oe_next = 1'b0;
          end else begin
            state_next = data_sync ? ST_ERROR : ST_WAIT_IDLE;
          end
        end else if (timer == TIMEOUT_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_WAIT_IDLE: begin
        if (clock_sync && data_sync) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (timer == TIMEOUT_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next == ST_ERROR) begin
      clock_oe_next = 1'b0;
      data_oe_next  = 1'b0;
    end
    if (state_next != state) begin
      timer_next = '0;
    end
  end

  assign device_clock_oe       = clock_oe_q;
  assign device_data_oe        = data_oe_q;
  assign host.busy             = (state != ST_IDLE) && (state != ST_ERROR);
  assign host.receiver_inhibit = host.busy;
  assign host.done             = done_q;
  assign host.error            = (state == ST_ERROR);

endmodule

// File: tb/tb_kfps2kb_send_command.sv
// Directed bench for the PS/2 command transmitter with an emulated keyboard
// that clocks the bus, samples bits on rising edges and optionally ACKs.
module tb_kfps2kb_send_command;
  import kfps2kb_pkg::*;

  localparam int INHIBIT_CYCLES = 20;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF_PERIOD    = 30;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dev_clock_low = 1'b0;
  logic dev_data_low  = 1'b0;
  logic device_clock_oe;
  logic device_data_oe;
  logic clock_line;
  logic data_line;

  int cycle = 0;
  int done_count = 0;
  int error_count = 0;
  int overlap_count = 0;
  int assertions = 0;
  int failures = 0;

  kfps2kb_send_command_if host ();

  // Open-drain bus with pull-up: low if either side pulls it.
  assign clock_line = ~(device_clock_oe | dev_clock_low);
  assign data_line  = ~(device_data_oe | dev_data_low);

  kfps2kb_send_command #(
    .INHIBIT_CYCLES (INHIBIT_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .device_clock    (clock_line),
    .device_data     (data_line),
    .device_clock_oe (device_clock_oe),
    .device_data_oe  (device_data_oe),
    .host            (host)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  always @(negedge clock) begin
    if (host.done) begin
      done_count <= done_count + 1;
      if (host.busy) overlap_count <= overlap_count + 1;
    end
    if (host.error) begin
      error_count <= error_count + 1;
      if (host.busy) overlap_count <= overlap_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd);
    @(posedge clock);
    #1;
    host.send_request = 1'b1;
    host.send_data    = cmd;
    @(posedge clock);
    #1;
    host.send_request = 1'b0;
  endtask

  task automatic waitRequest(output int req_cycle, output logic found);
    found = 1'b0;
    req_cycle = 0;
    for (int i = 0; i < INHIBIT_CYCLES + 20; i++) begin
      @(negedge clock);
      if (device_data_oe) begin
        found = 1'b1;
        req_cycle = cycle;
        break;
      end
    end
  endtask

  // Keyboard model: start bit read before the first fall, bit k read just before rise k.
  task automatic deviceTransfer(input logic give_ack, input int abort_after_fall, output logic [10:0] bits);
    bits = '0;
    repeat (HALF_PERIOD) @(negedge clock);
    bits[0] = data_line;
    for (int k = 1; k <= PS2_FALL_ACK; k++) begin
      @(posedge clock);
      #1 dev_clock_low = 1'b1;
      if (k == abort_after_fall) return;
      repeat (HALF_PERIOD) @(negedge clock);
      if (k <= PS2_FALL_STOP) bits[k] = data_line;
      if (k == PS2_FALL_STOP) dev_data_low = give_ack;
      @(posedge clock);
      #1 dev_clock_low = 1'b0;
      if (k == PS2_FALL_ACK) dev_data_low = 1'b0;
      repeat (HALF_PERIOD) @(negedge clock);
    end
  endtask

  initial begin
    int accept_cycle;
    int req_cycle;
    int err_cycle;
    int done_base;
    int error_base;
    logic found;
    logic [10:0] bits;

    host.send_request = 1'b0;
    host.send_data    = 8'h00;

    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", 32'({device_clock_oe, device_data_oe, host.busy, host.done, host.error, host.receiver_inhibit}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("idle_outputs", 32'({device_clock_oe, device_data_oe, host.busy, host.done, host.error}), 32'd0);

    // 0xED with ACK
    done_base = done_count; error_base = error_count;
    applyStimulus(8'hED);
    @(negedge clock);
    accept_cycle = cycle;
    checkOutput("busy_after_accept", 32'(host.busy), 32'd1);
    checkOutput("inhibit_flag", 32'(host.receiver_inhibit), 32'd1);
    checkOutput("oe_during_inhibit", 32'({device_clock_oe, device_data_oe}), 32'b10);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_ed", 32'(found), 32'd1);
    checkOutput("inhibit_length", 32'(req_cycle - accept_cycle), 32'(INHIBIT_CYCLES));
    checkOutput("oe_at_request", 32'({device_clock_oe, device_data_oe}), 32'b01);
    deviceTransfer(1'b1, 0, bits);
    checkOutput("wire_bits_ed", 32'(bits), 32'h7DA);
    repeat (5) @(negedge clock);
    checkOutput("done_ed", 32'(done_count - done_base), 32'd1);
    checkOutput("no_error_ed", 32'(error_count - error_base), 32'd0);
    checkOutput("idle_after_ed", 32'({host.busy, device_clock_oe, device_data_oe}), 32'd0);

    // 0x00: parity bit 1
    done_base = done_count;
    applyStimulus(8'h00);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_00", 32'(found), 32'd1);
    deviceTransfer(1'b1, 0, bits);
    checkOutput("wire_bits_00", 32'(bits), 32'h600);
    repeat (5) @(negedge clock);
    checkOutput("done_00", 32'(done_count - done_base), 32'd1);

    // Device never clocks
    done_base = done_count; error_base = error_count;
    applyStimulus(8'h12);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_to", 32'(found), 32'd1);
    for (int i = 0; i < TIMEOUT_CYCLES + 20; i++) begin
      if (host.error) break;
      @(negedge clock);
    end
    err_cycle = cycle;
    checkOutput("timeout_error", 32'(host.error), 32'd1);
    checkOutput("timeout_latency", 32'(err_cycle - req_cycle), 32'(TIMEOUT_CYCLES + 1));
    checkOutput("timeout_oe_released", 32'({device_clock_oe, device_data_oe}), 32'd0);
    repeat (3) @(negedge clock);
    checkOutput("timeout_idle", 32'({host.busy, device_clock_oe, device_data_oe}), 32'd0);
    checkOutput("timeout_error_count", 32'(error_count - error_base), 32'd1);
    checkOutput("timeout_no_done", 32'(done_count - done_base), 32'd0);

    // No ACK at falling edge 11
    done_base = done_count; error_base = error_count;
    applyStimulus(8'hC5);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_nack", 32'(found), 32'd1);
    deviceTransfer(1'b0, 0, bits);
    repeat (5) @(negedge clock);
    checkOutput("nack_error", 32'(error_count - error_base), 32'd1);
    checkOutput("nack_no_done", 32'(done_count - done_base), 32'd0);

    // Second request while busy is dropped
    done_base = done_count;
    applyStimulus(8'hA3);
    applyStimulus(8'h55);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_a3", 32'(found), 32'd1);
    deviceTransfer(1'b1, 0, bits);
    checkOutput("wire_bits_a3", 32'(bits), 32'h746);
    repeat (40) @(negedge clock);
    checkOutput("busy_drop_done", 32'(done_count - done_base), 32'd1);
    checkOutput("no_queued_send", 32'({host.busy, device_clock_oe, device_data_oe}), 32'd0);

    // Reset after falling edge 5, then a clean 0xFF
    done_base = done_count; error_base = error_count;
    applyStimulus(8'h0F);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_0f", 32'(found), 32'd1);
    deviceTransfer(1'b1, 5, bits);
    repeat (6) @(negedge clock);
    checkOutput("data_oe_bit4", 32'(device_data_oe), 32'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_mid_frame", 32'({device_clock_oe, device_data_oe, host.busy, host.receiver_inhibit}), 32'd0);
    dev_clock_low = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    applyStimulus(8'hFF);
    waitRequest(req_cycle, found);
    checkOutput("request_seen_ff", 32'(found), 32'd1);
    deviceTransfer(1'b1, 0, bits);
    checkOutput("wire_bits_ff", 32'(bits), 32'h7FE);
    repeat (5) @(negedge clock);
    checkOutput("done_ff", 32'(done_count - done_base), 32'd1);
    checkOutput("no_error_ff", 32'(error_count - error_base), 32'd0);
    checkOutput("status_busy_overlap", 32'(overlap_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
